// File: rtl/usb_tx_sequencer.sv
// Shares the USB tx packet encoder between the handshake responder and the data path:
// arbitration, bus turnaround, one-cycle packet command, start timeout and completion report.
module usb_tx_sequencer #(
   parameter int unsigned TURNAROUND    = 2,
   parameter int unsigned START_TIMEOUT = 8,
   parameter int unsigned MAX_BYTES     = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       hs_req,
   input  logic       hs_nak,
   input  logic       data_req,
   input  logic [6:0] buffer_occupancy,
   input  logic       tx_transfer_active,
   input  logic       tx_error,
   output logic [1:0] tx_packet,
   output logic       hs_done,
   output logic       data_done,
   output logic       seq_error,
   output logic       busy
);

   // state        | meaning
   // S_IDLE       | no owner; arbitrate hs_req over data_req
   // S_TURN       | bus turnaround, counting TURNAROUND cycles
   // S_ISSUE      | latched command on tx_packet for one cycle
   // S_WAIT_START | waiting for tx_transfer_active, bounded by START_TIMEOUT
   // S_ACTIVE     | packet on the bus, watching for fall or tx_error
   // S_DONE       | one-cycle done pulse to the owner
   typedef enum logic [2:0] {
      S_IDLE,
      S_TURN,
      S_ISSUE,
      S_WAIT_START,
      S_ACTIVE,
      S_DONE
   } state_t;

   localparam logic [7:0] TURN_LOAD  = (TURNAROUND == 0) ? 8'd0 : 8'(TURNAROUND - 1);
   localparam logic [7:0] START_LOAD = 8'(START_TIMEOUT - 1);
   localparam logic [7:0] MAX_OCC    = 8'(MAX_BYTES);

   localparam logic [1:0] PKT_NONE  = 2'b00;
   localparam logic [1:0] PKT_DATA0 = 2'b01;
   localparam logic [1:0] PKT_ACK   = 2'b10;
   localparam logic [1:0] PKT_NAK   = 2'b11;

   state_t     state_q, state_nxt;
   logic [7:0] cnt_q, cnt_nxt;
   logic       owner_hs_q, owner_hs_nxt;
   logic [1:0] cmd_q, cmd_nxt;
   logic       err_nxt;
   logic       oversize;

   assign oversize = {1'b0, buffer_occupancy} > MAX_OCC;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= 8'd0;
         owner_hs_q <= 1'b0;
         cmd_q      <= PKT_NONE;
         tx_packet  <= PKT_NONE;
         hs_done    <= 1'b0;
         data_done  <= 1'b0;
         seq_error  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         cnt_q      <= cnt_nxt;
         owner_hs_q <= owner_hs_nxt;
         cmd_q      <= cmd_nxt;
         // outputs are decoded from the next state so they are flops aligned with the state
         tx_packet  <= (state_nxt == S_ISSUE) ? cmd_nxt : PKT_NONE;
         hs_done    <= (state_nxt == S_DONE) && owner_hs_nxt;
         data_done  <= (state_nxt == S_DONE) && !owner_hs_nxt;
         seq_error  <= (state_nxt == S_DONE) && err_nxt;
         busy       <= (state_nxt != S_IDLE);
      end
   end

   always_comb begin
      state_nxt    = state_q;
      cnt_nxt      = cnt_q;
      owner_hs_nxt = owner_hs_q;
      cmd_nxt      = cmd_q;
      err_nxt      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (hs_req || data_req) begin
               owner_hs_nxt = hs_req;
               if (hs_req) begin
                  cmd_nxt = hs_nak ? PKT_NAK : PKT_ACK;
               end else begin
                  cmd_nxt = PKT_DATA0;
               end
               if (!hs_req && oversize) begin
                  state_nxt = S_DONE;
                  err_nxt   = 1'b1;
               end else if (TURNAROUND == 0) begin
                  state_nxt = S_ISSUE;
               end else begin
                  state_nxt = S_TURN;
                  cnt_nxt   = TURN_LOAD;
               end
            end
         end
         S_TURN: begin
            if (cnt_q == 8'd0) begin
               state_nxt = S_ISSUE;
            end else begin
               cnt_nxt = cnt_q - 8'd1;
            end
         end
         S_ISSUE: begin
            state_nxt = S_WAIT_START;
            cnt_nxt   = START_LOAD;
         end
         S_WAIT_START: begin
            if (tx_error) begin
               state_nxt = S_DONE;
               err_nxt   = 1'b1;
            end else if (tx_transfer_active) begin
               state_nxt = S_ACTIVE;
            end else if (cnt_q == 8'd0) begin
               state_nxt = S_DONE;
               err_nxt   = 1'b1;
            end else begin
               cnt_nxt = cnt_q - 8'd1;
            end
         end
         S_ACTIVE: begin
            if (tx_error) begin
               state_nxt = S_DONE;
               err_nxt   = 1'b1;
            end else if (!tx_transfer_active) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
            cnt_nxt   = 8'd0;
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = 8'd0;
         end
      endcase
   end

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Directed bench for usb_tx_sequencer: stimulus pushes expected packet/done events with their
// cycle numbers; a negedge monitor pops and compares every event the DUT presents.
module tb_usb_tx_sequencer;

   logic       tb_clk = 1'b0;
   logic       rst;
   logic       hs_req;
   logic       hs_nak;
   logic       data_req;
   logic [6:0] buffer_occupancy;
   logic       tx_transfer_active;
   logic       tx_error;
   logic [1:0] tx_packet;
   logic       hs_done;
   logic       data_done;
   logic       seq_error;
   logic       busy;

   typedef struct {
      int         kind;   // 0 packet, 1 hs_done, 2 data_done
      logic [1:0] val;    // packet code, or seq_error in bit 0
      int         cyc;
   } ev_t;

   ev_t exp_q[$];
   int  total = 0;
   int  bad   = 0;
   int  cyc   = 0;
   int  b;

   usb_tx_sequencer #(
      .TURNAROUND(2),
      .START_TIMEOUT(8),
      .MAX_BYTES(64)
   ) dut (
      .clk(tb_clk),
      .rst(rst),
      .hs_req(hs_req),
      .hs_nak(hs_nak),
      .data_req(data_req),
      .buffer_occupancy(buffer_occupancy),
      .tx_transfer_active(tx_transfer_active),
      .tx_error(tx_error),
      .tx_packet(tx_packet),
      .hs_done(hs_done),
      .data_done(data_done),
      .seq_error(seq_error),
      .busy(busy)
   );

   always #5 tb_clk = ~tb_clk;

   always @(posedge tb_clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int kind, input logic [1:0] val, input int c);
      ev_t e;
      e.kind = kind;
      e.val  = val;
      e.cyc  = c;
      exp_q.push_back(e);
   endtask

   task automatic see(input int kind, input logic [1:0] val);
      ev_t e;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL unexpected_event: got kind=%0d val=%0d at cycle %0d, expected none", kind, val, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.val != val || e.cyc != cyc) begin
            bad++;
            $display("FAIL event: got kind=%0d val=%0d cycle=%0d expected kind=%0d val=%0d cycle=%0d",
                     kind, val, cyc, e.kind, e.val, e.cyc);
         end
      end
   endtask

   always @(negedge tb_clk) begin
      if (!rst) begin
         if (tx_packet != 2'b00) see(0, tx_packet);
         if (hs_done) see(1, {1'b0, seq_error});
         if (data_done) see(2, {1'b0, seq_error});
         if (seq_error && !hs_done && !data_done) begin
            total++;
            bad++;
            $display("FAIL stray_seq_error: got 1 expected 0 at cycle %0d", cyc);
         end
      end
   end

   task automatic step();
      @(posedge tb_clk);
      #1;
   endtask

   task automatic at(input int c);
      while (cyc < c) step();
   endtask

   initial begin
      rst                = 1'b1;
      hs_req             = 1'b0;
      hs_nak             = 1'b0;
      data_req           = 1'b0;
      buffer_occupancy   = 7'd0;
      tx_transfer_active = 1'b0;
      tx_error           = 1'b0;
      repeat (3) step();
      @(negedge tb_clk);
      check("rst_tx_packet", int'(tx_packet), 0);
      check("rst_hs_done", int'(hs_done), 0);
      check("rst_data_done", int'(data_done), 0);
      check("rst_seq_error", int'(seq_error), 0);
      check("rst_busy", int'(busy), 0);
      step();
      rst = 1'b0;
      step();

      // single ACK, active 5..19
      step();
      b = cyc;
      hs_req = 1'b1;
      hs_nak = 1'b0;
      push(0, 2'b10, b + 3);
      push(1, 2'b00, b + 21);
      @(negedge tb_clk);
      check("ack_busy_c0", int'(busy), 0);
      at(b + 1);
      @(negedge tb_clk);
      check("ack_busy_c1", int'(busy), 1);
      at(b + 5);
      tx_transfer_active = 1'b1;
      at(b + 20);
      tx_transfer_active = 1'b0;
      at(b + 21);
      @(negedge tb_clk);
      check("ack_busy_done", int'(busy), 1);
      at(b + 22);
      hs_req = 1'b0;
      @(negedge tb_clk);
      check("ack_busy_after", int'(busy), 0);

      // data, 2 bytes
      at(b + 24);
      b = cyc;
      data_req = 1'b1;
      buffer_occupancy = 7'd2;
      push(0, 2'b01, b + 3);
      push(2, 2'b00, b + 11);
      at(b + 4);
      tx_transfer_active = 1'b1;
      at(b + 10);
      tx_transfer_active = 1'b0;
      at(b + 12);
      data_req = 1'b0;

      // simultaneous NAK and zero-length data
      at(b + 14);
      b = cyc;
      hs_req = 1'b1;
      hs_nak = 1'b1;
      data_req = 1'b1;
      buffer_occupancy = 7'd0;
      push(0, 2'b11, b + 3);
      push(1, 2'b00, b + 9);
      push(0, 2'b01, b + 13);
      push(2, 2'b00, b + 17);
      at(b + 4);
      tx_transfer_active = 1'b1;
      at(b + 8);
      tx_transfer_active = 1'b0;
      at(b + 10);
      hs_req = 1'b0;
      hs_nak = 1'b0;
      at(b + 14);
      tx_transfer_active = 1'b1;
      at(b + 16);
      tx_transfer_active = 1'b0;
      at(b + 18);
      data_req = 1'b0;

      // oversize rejected without a packet
      at(b + 20);
      b = cyc;
      data_req = 1'b1;
      buffer_occupancy = 7'd65;
      push(2, 2'b01, b + 1);
      at(b + 1);
      @(negedge tb_clk);
      check("over_busy", int'(busy), 1);
      at(b + 2);
      data_req = 1'b0;
      @(negedge tb_clk);
      check("over_busy_after", int'(busy), 0);

      // MAX_BYTES is legal; start timeout
      at(b + 4);
      b = cyc;
      data_req = 1'b1;
      buffer_occupancy = 7'd64;
      push(0, 2'b01, b + 3);
      push(2, 2'b01, b + 12);
      at(b + 13);
      data_req = 1'b0;

      // tx_error in ACTIVE
      at(b + 15);
      b = cyc;
      hs_req = 1'b1;
      push(0, 2'b10, b + 3);
      push(1, 2'b01, b + 8);
      at(b + 4);
      tx_transfer_active = 1'b1;
      at(b + 7);
      tx_error = 1'b1;
      at(b + 8);
      tx_error = 1'b0;
      tx_transfer_active = 1'b0;
      at(b + 9);
      hs_req = 1'b0;

      // reset in ACTIVE abandons silently
      at(b + 11);
      b = cyc;
      data_req = 1'b1;
      buffer_occupancy = 7'd5;
      push(0, 2'b01, b + 3);
      at(b + 4);
      tx_transfer_active = 1'b1;
      at(b + 7);
      @(negedge tb_clk);
      check("rstmid_busy_before", int'(busy), 1);
      rst = 1'b1;
      at(b + 8);
      rst = 1'b0;
      data_req = 1'b0;
      tx_transfer_active = 1'b0;
      @(negedge tb_clk);
      check("rstmid_tx_packet", int'(tx_packet), 0);
      check("rstmid_hs_done", int'(hs_done), 0);
      check("rstmid_data_done", int'(data_done), 0);
      check("rstmid_seq_error", int'(seq_error), 0);
      check("rstmid_busy", int'(busy), 0);
      at(b + 14);
      @(negedge tb_clk);
      check("queue_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
